// File: rtl/synth_update_pkg.sv
// Shared types and constants for the synthesizer update controller.
// Slot state encodings are fixed so they stay compatible with existing consumers.
package synth_update_pkg;

    localparam int unsigned RATE_W  = 32;
    localparam int unsigned DEF_NCH = 4;
    localparam int unsigned DEF_PW  = 24;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PEND_INIT  = 2'd1,
        PEND_EPOCH = 2'd2
    } slot_state_t;

    // Channel-select width; a single-channel build still needs a 1-bit select.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/synth_update_slot.sv
// One channel: staged phase-rate register and its pending-update FSM.
// A write is only taken while IDLE; the pending update commits on intr_pulse or epoch_in.
module synth_update_slot
    import synth_update_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_sel,
    input  logic [RATE_W-1:0] wr_rate,
    input  logic              wr_init,
    input  logic              intr_pulse,
    input  logic              epoch_in,
    output logic              busy,
    output logic              wr_reject,
    output logic [RATE_W-1:0] phase_rate,
    output logic              doinit,
    output logic              epoch_pulse
);

    slot_state_t state;
    slot_state_t state_nxt;
    logic        wr_accept;

    assign busy      = (state != IDLE);
    assign wr_accept = wr_sel && (state == IDLE);
    assign wr_reject = wr_sel && (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (wr_sel) begin
                    state_nxt = wr_init ? PEND_INIT : PEND_EPOCH;
                end
            end
            PEND_INIT: begin
                if (intr_pulse) begin
                    state_nxt = IDLE;
                end
            end
            PEND_EPOCH: begin
                if (epoch_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Rate is frozen for the whole pending window; only an accepted write moves it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_rate <= '0;
        end else if (wr_accept) begin
            phase_rate <= wr_rate;
        end
    end

    assign doinit      = (state == PEND_INIT);
    assign epoch_pulse = (state == PEND_EPOCH) && epoch_in;

endmodule

// File: rtl/synth_update_ctrl.sv
// Sequences rate updates for NCH channel synthesizers against a shared interrupt
// timebase and an external epoch strobe, and tracks the phase-snapshot handshake.
module synth_update_ctrl
    import synth_update_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    parameter int unsigned PW  = DEF_PW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [PW-1:0]           intr_period,
    input  logic                    epoch_in,
    input  logic                    wr_en,
    input  logic [ch_w(NCH)-1:0]    wr_ch,
    input  logic [RATE_W-1:0]       wr_rate,
    input  logic                    wr_init,
    output logic                    wr_err,
    output logic [NCH-1:0]          ch_busy,
    output logic [NCH*RATE_W-1:0]   phase_rate,
    output logic [NCH-1:0]          doinit,
    output logic                    intr_pulse,
    output logic [NCH-1:0]          epoch_pulse,
    output logic                    snap_valid,
    input  logic                    snap_ack,
    output logic                    snap_ovr
);

    localparam int unsigned CH_W = ch_w(NCH);

    logic [PW-1:0]  tb_cnt;
    logic           tb_run;
    logic [NCH-1:0] wr_sel;
    logic [NCH-1:0] wr_reject;
    logic           wr_ch_valid;
    logic           wr_err_nxt;
    logic           snap_new_ovr;

    // Timebase: compared against the live period so a shortened period fires at once.
    assign tb_run     = enable && (intr_period != '0);
    assign intr_pulse = reset_n && tb_run && (tb_cnt >= (intr_period - PW'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_cnt <= '0;
        end else if (!tb_run || intr_pulse) begin
            tb_cnt <= '0;
        end else begin
            tb_cnt <= tb_cnt + PW'(1);
        end
    end

    assign wr_ch_valid = (32'(wr_ch) < NCH);

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        assign wr_sel[k] = wr_en && (wr_ch == CH_W'(k));

        synth_update_slot u_slot (
            .clk         (clk),
            .reset_n     (reset_n),
            .wr_sel      (wr_sel[k]),
            .wr_rate     (wr_rate),
            .wr_init     (wr_init),
            .intr_pulse  (intr_pulse),
            .epoch_in    (epoch_in),
            .busy        (ch_busy[k]),
            .wr_reject   (wr_reject[k]),
            .phase_rate  (phase_rate[k*RATE_W +: RATE_W]),
            .doinit      (doinit[k]),
            .epoch_pulse (epoch_pulse[k])
        );
    end

    // Out-of-range channel numbers are rejected the same way as busy channels.
    assign wr_err_nxt = wr_en && (!wr_ch_valid || (|wr_reject));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_err_nxt;
        end
    end

    // Snapshot: an ack landing with a fresh interrupt neither clears nor overruns.
    assign snap_new_ovr = intr_pulse && snap_valid && !snap_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_valid <= 1'b0;
            snap_ovr   <= 1'b0;
        end else begin
            if (intr_pulse) begin
                snap_valid <= 1'b1;
            end else if (snap_ack && snap_valid) begin
                snap_valid <= 1'b0;
            end

            if (snap_new_ovr) begin
                snap_ovr <= 1'b1;
            end else if (snap_ack && !intr_pulse) begin
                snap_ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_synth_update_ctrl.sv
// Self-checking bench for synth_update_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_synth_update_ctrl;

    localparam int NCH = 4;
    localparam int PW  = 24;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  enable;
    logic [PW-1:0]         intr_period;
    logic                  epoch_in;
    logic                  wr_en;
    logic [1:0]            wr_ch;
    logic [31:0]           wr_rate;
    logic                  wr_init;
    logic                  wr_err;
    logic [NCH-1:0]        ch_busy;
    logic [NCH*32-1:0]     phase_rate;
    logic [NCH-1:0]        doinit;
    logic                  intr_pulse;
    logic [NCH-1:0]        epoch_pulse;
    logic                  snap_valid;
    logic                  snap_ack;
    logic                  snap_ovr;

    always #5 clk = ~clk;

    synth_update_ctrl #(.NCH(NCH), .PW(PW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .intr_period (intr_period),
        .epoch_in    (epoch_in),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_rate     (wr_rate),
        .wr_init     (wr_init),
        .wr_err      (wr_err),
        .ch_busy     (ch_busy),
        .phase_rate  (phase_rate),
        .doinit      (doinit),
        .intr_pulse  (intr_pulse),
        .epoch_pulse (epoch_pulse),
        .snap_valid  (snap_valid),
        .snap_ack    (snap_ack),
        .snap_ovr    (snap_ovr)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: cycles elapsed since the last interrupt, and what each channel waits for
    // (0 = nothing, 1 = next interrupt, 2 = next epoch).
    int unsigned  m_elapsed;
    int           m_mode [NCH];
    logic [31:0]  m_rate [NCH];
    bit           m_err, m_sv, m_ovr;

    function automatic bit m_intr();
        if (!reset_n || !enable || intr_period == 0) return 1'b0;
        return (m_elapsed + 1) >= int'(intr_period);
    endfunction

    task automatic model_reset();
        m_elapsed = 0;
        m_err = 0; m_sv = 0; m_ovr = 0;
        for (int k = 0; k < NCH; k++) begin
            m_mode[k] = 0;
            m_rate[k] = '0;
        end
    endtask

    task automatic settle_check();
        logic [NCH-1:0] e_busy, e_init, e_epoch;
        #1;
        for (int k = 0; k < NCH; k++) begin
            e_busy[k]  = (m_mode[k] != 0);
            e_init[k]  = (m_mode[k] == 1);
            e_epoch[k] = (m_mode[k] == 2) && epoch_in;
        end
        check_val("intr_pulse", intr_pulse, m_intr());
        check_val("wr_err", wr_err, m_err);
        check_val("ch_busy", ch_busy, e_busy);
        check_val("doinit", doinit, e_init);
        check_val("epoch_pulse", epoch_pulse, e_epoch);
        check_val("snap_valid", snap_valid, m_sv);
        check_val("snap_ovr", snap_ovr, m_ovr);
        for (int k = 0; k < NCH; k++)
            check_val($sformatf("phase_rate%0d", k), phase_rate[k*32 +: 32], m_rate[k]);
    endtask

    task automatic advance();
        bit intr, acc;
        if (!reset_n) begin
            model_reset();
        end else begin
            intr = m_intr();
            acc  = wr_en && (m_mode[wr_ch] == 0);
            m_err = wr_en && !acc;
            for (int k = 0; k < NCH; k++) begin
                if ((m_mode[k] == 1 && intr) || (m_mode[k] == 2 && epoch_in))
                    m_mode[k] = 0;
            end
            if (acc) begin
                m_rate[wr_ch] = wr_rate;
                m_mode[wr_ch] = wr_init ? 1 : 2;
            end
            if (intr && m_sv && !snap_ack) m_ovr = 1;
            else if (snap_ack && !intr)    m_ovr = 0;
            if (intr)                      m_sv = 1;
            else if (snap_ack && m_sv)     m_sv = 0;
            if (!enable || intr_period == 0 || intr) m_elapsed = 0;
            else                                     m_elapsed++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = 0; epoch_in = 0; snap_ack = 0; wr_init = 0; wr_ch = 0; wr_rate = '0;
    endtask

    initial begin
        int seen;
        reset_n = 0; enable = 0; intr_period = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        settle_check();
        check_val("reset_busy", ch_busy, 0);
        check_val("reset_snap", snap_valid, 0);
        advance();

        // Main directed scenario, cycle 0 is the first cycle after release.
        intr_period = 10; enable = 1; reset_n = 1;
        for (int c = 0; c < 56; c++) begin
            idle_inputs();
            case (c)
                0:  begin wr_en = 1; wr_ch = 1; wr_rate = 32'h0100_0000; wr_init = 1; end
                2:  begin wr_en = 1; wr_ch = 2; wr_rate = 32'h00AB_CDEF; wr_init = 0; end
                5:  begin wr_en = 1; wr_ch = 2; wr_rate = 32'h1234_5678; wr_init = 0; end
                29: snap_ack = 1;
                31: snap_ack = 1;
                50: epoch_in = 1;
                default: ;
            endcase
            settle_check();
            if (c < 30) check_val("timebase", intr_pulse, (c == 9 || c == 19 || c == 29));
            if (c >= 1 && c <= 10) check_val("doinit1", doinit[1], (c <= 9));
            if (c == 1) check_val("rate1", phase_rate[63:32], 32'h0100_0000);
            if (c == 6 || c == 7) check_val("wr_err_pulse", wr_err, (c == 6));
            if (c >= 6 && c <= 50) check_val("rate2_hold", phase_rate[95:64], 32'h00AB_CDEF);
            if (c >= 49 && c <= 51) check_val("epoch2", epoch_pulse, (c == 50) ? 4'b0100 : 4'b0000);
            if (c == 51) check_val("busy2_clear", ch_busy[2], 0);
            if (c == 20) check_val("ovr_set", snap_ovr, 1);
            if (c == 30) begin
                check_val("ack_coincident_valid", snap_valid, 1);
                check_val("ack_coincident_ovr", snap_ovr, 1);
            end
            advance();
        end

        // Timebase disabled by a zero period.
        intr_period = 0;
        for (int c = 0; c < 30; c++) begin
            idle_inputs();
            settle_check();
            check_val("period0_quiet", intr_pulse, 0);
            advance();
        end

        // Reset while channel 0 waits for an interrupt drops the update.
        intr_period = 10;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) begin wr_en = 1; wr_ch = 0; wr_rate = 32'hDEAD_BEEF; wr_init = 1; end
            settle_check();
            if (c == 4) check_val("pend_before_reset", doinit[0], 1);
            advance();
        end
        reset_n = 0;
        model_reset();
        settle_check();
        check_val("reset_rate0", phase_rate[31:0], 0);
        check_val("reset_doinit", doinit, 0);
        advance();
        reset_n = 1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            idle_inputs();
            settle_check();
            check_val("post_reset_doinit0", doinit[0], 0);
            check_val("post_reset_busy", ch_busy, 0);
            if (intr_pulse) seen++;
            advance();
        end
        check_val("post_reset_intr_seen", (seen >= 1), 1);

        // Randomized traffic including mid-count period changes and stray resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) intr_period = PW'($urandom_range(0, 12));
            enable   = ($urandom_range(0, 19) != 0);
            epoch_in = ($urandom_range(0, 7) == 0);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_ch    = 2'($urandom_range(0, NCH - 1));
            wr_rate  = $urandom;
            wr_init  = 1'($urandom_range(0, 1));
            snap_ack = ($urandom_range(0, 2) == 0);
            reset_n  = ($urandom_range(0, 499) != 0);
            if (!reset_n) model_reset();
            settle_check();
            advance();
        end
        reset_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
